car_sensor_emulator: RTL and testbench

- Generates the two-beam sensor waveform (a, b) that car_detector_fsm decodes. Each accepted command produces one complete car-enter or car-exit sequence.
- Used as a bench and bring-up stimulus source: it drives the detector's a/b inputs in place of the physical sensors.
- Each sensor phase lasts a programmable number of clock cycles.

---
 rtl/car_sensor_emulator.sv | 135 +++++++++++++
 tb/tb_car_sensor_emulator.sv | 137 +++++++++++++
 2 files changed

// File: rtl/car_sensor_emulator.sv
// car_sensor_emulator - two-beam (a,b) car enter/exit waveform generator.
// Optional backout sequences enabled by defining CAR_EMU_BACKOUT_EN.
module car_sensor_emulator #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [DWELL_W-1:0] cmd_dwell,
`ifdef CAR_EMU_BACKOUT_EN
  input  logic               cmd_backout,
`endif
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    PH2  = 3'd2,
    PH3  = 3'd3,
    GAP  = 3'd4
  } state_t;

  localparam logic [DWELL_W-1:0] ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               dir_q, dir_d;
  logic               backout_q, backout_d;
  logic               a_q, a_d;
  logic               b_q, b_d;
  logic               backout_in;

`ifdef CAR_EMU_BACKOUT_EN
  assign backout_in = cmd_backout;
`else
  assign backout_in = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dwell_d   = dwell_q;
    dir_d     = dir_q;
    backout_d = backout_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d   = PH1;
          dir_d     = cmd_dir;
          backout_d = backout_in;
          dwell_d   = (cmd_dwell == '0) ? ONE : cmd_dwell;
          cnt_d     = dwell_d - ONE;
        end
      end
      PH1, PH2, PH3: begin
        if (cnt_q == '0) begin
          state_d = (state_q == PH1) ? PH2 : (state_q == PH2) ? PH3 : GAP;
          cnt_d   = dwell_q - ONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Beams are decoded from the next state so a/b are plain flops aligned to phase entry.
  always_comb begin
    a_d = 1'b0;
    b_d = 1'b0;
    case (state_d)
      PH1: begin
        a_d = ~dir_d;
        b_d = dir_d;
      end
      PH2: begin
        a_d = 1'b1;
        b_d = 1'b1;
      end
      PH3: begin
        a_d = backout_d ? ~dir_d : dir_d;
        b_d = backout_d ? dir_d : ~dir_d;
      end
      default: begin
        a_d = 1'b0;
        b_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dwell_q   <= '0;
      dir_q     <= 1'b0;
      backout_q <= 1'b0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dwell_q   <= dwell_d;
      dir_q     <= dir_d;
      backout_q <= backout_d;
      a_q       <= a_d;
      b_q       <= b_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == GAP) && (cnt_q == '0);
  assign a         = a_q;
  assign b         = b_q;

endmodule

// File: tb/tb_car_sensor_emulator.sv
// tb/tb_car_sensor_emulator.sv - directed self-checking bench for car_sensor_emulator.
module tb_car_sensor_emulator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_dwell = '0;
  logic        cmd_backout = 1'b0;
  logic        a, b, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  car_sensor_emulator #(.DWELL_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_dwell (cmd_dwell),
`ifdef CAR_EMU_BACKOUT_EN
    .cmd_backout (cmd_backout),
`endif
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_ab(input logic dir, input logic bo, input int ph);
    logic [1:0] r;
    case (ph)
      0: r = dir ? 2'b01 : 2'b10;
      1: r = 2'b11;
      2: r = (dir ^ bo) ? 2'b10 : 2'b01;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // Called #1 after an edge in a cycle where cmd_ready is expected high.
  // With mutate set, cmd_valid stays high and dir/dwell are scrambled after accept.
  task automatic run_seq(input logic dir, input logic [15:0] dwell, input logic bo,
                         input logic mutate);
    int         d;
    logic [1:0] prev, cur;
    d = (dwell == 0) ? 1 : int'(dwell);
    check("ready_pre", cmd_ready, 1);
    cmd_valid   = 1'b1;
    cmd_dir     = dir;
    cmd_dwell   = dwell;
    cmd_backout = bo;
    prev = {a, b};
    @(posedge clk); #1;
    if (mutate) begin
      cmd_dir     = ~dir;
      cmd_dwell   = 16'd7;
      cmd_backout = ~bo;
    end else begin
      cmd_valid = 1'b0;
    end
    for (int k = 1; k <= 4 * d; k++) begin
      cur = {a, b};
      check("ab", cur, exp_ab(dir, bo, (k - 1) / d));
      check("gray", ((prev ^ cur) == 2'b11), 0);
      check("busy", busy, 1);
      check("done", done, (k == 4 * d));
      check("ready_busy", cmd_ready, 0);
      prev = cur;
      @(posedge clk); #1;
    end
    check("ready_post", cmd_ready, 1);
    check("ab_post", {a, b}, 2'b00);
    check("busy_post", busy, 0);
    check("done_post", done, 0);
  endtask

  initial begin
    #1;
    check("rst_ab", {a, b}, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cmd_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    run_seq(1'b0, 16'd3, 1'b0, 1'b0);
    run_seq(1'b1, 16'd2, 1'b0, 1'b0);
    run_seq(1'b0, 16'd0, 1'b0, 1'b0);
    run_seq(1'b0, 16'd1, 1'b0, 1'b1);
    run_seq(1'b1, 16'd7, 1'b0, 1'b0);
    run_seq(1'b1, 16'd1, 1'b0, 1'b0);

    // Reset in cycle 5 of a dwell=3 enter.
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_dwell = 16'd3; cmd_backout = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("mid_ab", {a, b}, 2'b11);
    #2 reset = 1'b0;
    #1;
    check("arst_ab", {a, b}, 2'b00);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    repeat (3) begin
      @(negedge clk);
      check("arst_hold_done", done, 0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check("arst_ready", cmd_ready, 1);
    check("arst_idle_ab", {a, b}, 2'b00);

`ifdef CAR_EMU_BACKOUT_EN
    run_seq(1'b0, 16'd2, 1'b1, 1'b0);
    run_seq(1'b1, 16'd2, 1'b1, 1'b0);
`endif
    run_seq(1'b0, 16'd2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
